spi_shift_ctrl: RTL and testbench
=================================

// Module: spi_shift_ctrl
// PURPOSE
//  Sequencer that drives a BitShift8L shifter (load/shift/inLSB) as a mode-0 SPI master byte engine.
//  Accepts a byte on start, serialises it MSB-first on mosi and collects miso LSB-first into the same shifter.
//  Generates sck and returns the received byte with a one-cycle done strobe.
//  Sits between the Hack memory-mapped I/O and an external SPI device (SD card / flash).
// PARAMETERS
//  CLK_DIV   4   clk cycles per sck half-period; legal range 1..255
// PORTS
//  clk      in   1  system clock; all logic on posedge
//  reset    in   1  synchronous, active-high reset
//  start    in   1  begin a transfer; sampled only in IDLE
//  tx_data  in   8  byte to send; sampled in the cycle start is accepted
//  busy     out  1  high from acceptance through the DONE cycle
//  done     out  1  one-cycle pulse; rx_data valid from this cycle on
//  rx_data  out  8  last received byte; held until the next done
//  sck      out  1  SPI clock; idle low
//  mosi     out  1  serial out = shifter out[7]
//  miso     in   1  serial in
//  csn      out  1  chip select, active low (present only with SPI_CS_AUTO_EN)
// BEHAVIOUR
//  - Internal BitShift8L instance: load=accept pulse, in=tx_data, inLSB=miso_q, shift=end-of-HIGH pulse.
//  - Reset values: busy=0, done=0, rx_data=8'h00, sck=0, csn=1, state=IDLE, bit_cnt=0, div_cnt=0, miso_q=0.
//  - States: IDLE, LOW, HIGH, DONE.
//    IDLE: start=1 -> load=1 this edge, bit_cnt<=0, div_cnt<=0, go LOW. start=0 -> stay.
//    LOW: sck=0 for CLK_DIV cycles; on last cycle sck<=1, miso_q<=miso, go HIGH.
//    HIGH: sck=1 for CLK_DIV cycles; on last cycle shift=1 (inLSB=miso_q), sck<=0, bit_cnt++.
//      bit_cnt was 7 -> go DONE; otherwise go LOW.
//    DONE: done=1, rx_data<=shifter value after 8th shift, busy still 1. Always -> IDLE next cycle.
//  - mosi = shifter out[7]; changes only at load or shift, so it is stable across every sck rising edge.
//  - Timing:
//    - done is high exactly 1+16*CLK_DIV cycles after the edge that accepted start.
//    - The next start is accepted no earlier than the cycle after DONE.
//  - Boundary conditions:
//    - start while busy: ignored, no queuing; tx_data changes while busy have no effect.
//    - start held high: a new transfer is accepted every IDLE cycle (one idle cycle between transfers).
//    - reset mid-transfer: next cycle in IDLE with reset values; the partial byte is discarded and done is never pulsed.
//    - bit_cnt is 3 bits; div_cnt is 8 bits and wraps to 0 at each phase change.
//  - load and shift are never asserted in the same cycle.
// CONFIGURATION
//  SPI_CS_AUTO_EN defined:
//    - csn port exists; csn<=0 on the accept edge and stays low through the DONE cycle.
//    - csn<=1 on the edge leaving DONE; csn=1 on reset.
//  SPI_CS_AUTO_EN undefined:
//    - No csn port; device select is handled externally by software.
// TESTING
//  1. CLK_DIV=2, reset 2 cycles, start tx=8'hA5, miso looped to mosi
//     -> mosi at sck rises 1,0,1,0,0,1,0,1; done at accept+33; rx_data=8'hA5.
//  2. tx=8'h00, miso tied 1 -> mosi 0 on all 8 bits; rx_data=8'hFF; busy=0 the cycle after done.
//  3. start pulsed again with tx=8'h3C 10 cycles into a transfer of 8'hC3 (loopback)
//     -> ignored; single done; rx_data=8'hC3.
//  4. reset asserted after 3 sck rises
//     -> next cycle busy=0, sck=0, rx_data=0, no done; then start 8'h81 -> rx_data=8'h81.
//  5. start held high, tx=8'h5A (loopback)
//     -> done pulses spaced 2+16*CLK_DIV cycles apart; rx_data=8'h5A each time.
//  6. SPI_CS_AUTO_EN defined -> csn low from the accept edge through done, high otherwise;
//     compile without it -> no csn port.

Source files
------------

// File: rtl/spi_shift_ctrl.sv
// rtl/spi_shift_ctrl.sv - mode-0 SPI master byte engine around a BitShift8L shifter
// Optional auto chip-select: define SPI_CS_AUTO_EN to get the csn port.

module bit_shift8l (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] d,
    input  logic       in_lsb,
    output logic [7:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= 8'h00;
        else if (load)
            q <= d;
        else if (shift)
            q <= {q[6:0], in_lsb};
    end
endmodule

module spi_shift_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
`ifdef SPI_CS_AUTO_EN
    ,
    output logic       csn
`endif
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] div_cnt;
    logic       miso_q;
    logic [7:0] sh_q;
    logic       div_last;
    logic       load;
    logic       shift;

    assign div_last = (div_cnt == DIV_LAST);
    assign load     = (state == IDLE) && start;
    assign shift    = (state == HIGH) && div_last;
    assign mosi     = sh_q[7];

    bit_shift8l u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .shift  (shift),
        .d      (tx_data),
        .in_lsb (miso_q),
        .q      (sh_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= 8'h00;
            sck     <= 1'b0;
            bit_cnt <= 3'd0;
            div_cnt <= 8'd0;
            miso_q  <= 1'b0;
`ifdef SPI_CS_AUTO_EN
            csn     <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOW;
                        busy    <= 1'b1;
                        bit_cnt <= 3'd0;
                        div_cnt <= 8'd0;
`ifdef SPI_CS_AUTO_EN
                        csn     <= 1'b0;
`endif
                    end
                end
                LOW: begin
                    if (div_last) begin
                        sck     <= 1'b1;
                        miso_q  <= miso;
                        div_cnt <= 8'd0;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        sck     <= 1'b0;
                        div_cnt <= 8'd0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            // Capture what the shifter holds after this same-edge 8th shift.
                            rx_data <= {sh_q[6:0], miso_q};
                        end else begin
                            state <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef SPI_CS_AUTO_EN
                    csn   <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb/tb_spi_shift_ctrl.sv - directed table-driven bench for spi_shift_ctrl at CLK_DIV=2
module tb_spi_shift_ctrl;
    localparam int D        = 2;
    localparam int DONE_CYC = 1 + 16 * D;

    logic       clk = 1'b0;
    logic       reset, start, miso;
    logic [7:0] tx_data;
    logic       busy, done, sck, mosi;
    logic [7:0] rx_data;
    logic       loop_en, miso_tie;
`ifdef SPI_CS_AUTO_EN
    logic       csn;
`endif

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;
    assign miso = loop_en ? mosi : miso_tie;

    spi_shift_ctrl #(.CLK_DIV(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso)
`ifdef SPI_CS_AUTO_EN
        ,
        .csn     (csn)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       lp;
        logic       tie;
        int         inj;
        logic [7:0] inj_tx;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic do_xfer(input vec_t v, input string tag);
        logic [7:0] bits;
        logic [7:0] rx_at_done;
        int         nrise, ndone, done_at;
        logic       prev_sck, busy_after, cs_ok;
        bits = 8'h00; rx_at_done = 8'h00; nrise = 0; ndone = 0; done_at = -1;
        prev_sck = 1'b0; busy_after = 1'b1; cs_ok = 1'b1;
        loop_en = v.lp; miso_tie = v.tie; tx_data = v.tx; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= DONE_CYC + 3; cyc++) begin
            if (sck && !prev_sck) begin
                bits = {bits[6:0], mosi};
                nrise++;
            end
            prev_sck = sck;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at    = cyc;
                    rx_at_done = rx_data;
                end
            end
            if (cyc == DONE_CYC + 1) busy_after = busy;
`ifdef SPI_CS_AUTO_EN
            if (csn !== ((cyc <= DONE_CYC) ? 1'b0 : 1'b1)) cs_ok = 1'b0;
`endif
            if (cyc <= DONE_CYC) tx_data = 8'($urandom);
            start = (cyc == v.inj);
            if (cyc == v.inj) tx_data = v.inj_tx;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, " sck_rises"}, nrise, 8);
        chk({tag, " mosi_bits"}, bits, v.tx);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " done_cycle"}, done_at, DONE_CYC);
        chk({tag, " rx_at_done"}, rx_at_done, v.exp_rx);
        chk({tag, " rx_held"}, rx_data, v.exp_rx);
        chk({tag, " busy_after_done"}, busy_after, 1'b0);
        chk({tag, " cs_window"}, cs_ok, 1'b1);
    endtask

    vec_t vecs[4];

    initial begin
        int nrise, ndone;
        int dcyc[4];
        logic prev_sck, rx_ok;

        vecs[0] = '{tx: 8'hA5, lp: 1'b1, tie: 1'b0, inj: -1, inj_tx: 8'h00, exp_rx: 8'hA5};
        vecs[1] = '{tx: 8'h00, lp: 1'b0, tie: 1'b1, inj: -1, inj_tx: 8'h00, exp_rx: 8'hFF};
        vecs[2] = '{tx: 8'hC3, lp: 1'b1, tie: 1'b0, inj: 10, inj_tx: 8'h3C, exp_rx: 8'hC3};
        vecs[3] = '{tx: 8'h7E, lp: 1'b0, tie: 1'b0, inj: -1, inj_tx: 8'h00, exp_rx: 8'h00};

        reset = 1'b1; start = 1'b0; tx_data = 8'h00; loop_en = 1'b0; miso_tie = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst rx_data", rx_data, 8'h00);
        chk("rst sck", sck, 1'b0);
`ifdef SPI_CS_AUTO_EN
        chk("rst csn", csn, 1'b1);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

        // Reset after the third sck rise discards the partial byte.
        loop_en = 1'b1; tx_data = 8'hF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; nrise = 0; prev_sck = 1'b0;
        for (int c = 0; c < 100 && nrise < 3; c++) begin
            @(posedge clk); #1;
            if (sck && !prev_sck) nrise++;
            prev_sck = sck;
        end
        chk("rst_mid reached_3_rises", nrise, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid busy", busy, 1'b0);
        chk("rst_mid sck", sck, 1'b0);
        chk("rst_mid rx_data", rx_data, 8'h00);
`ifdef SPI_CS_AUTO_EN
        chk("rst_mid csn", csn, 1'b1);
`endif
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) ndone++;
            @(posedge clk); #1;
        end
        chk("rst_mid no_activity", ndone, 0);
        do_xfer('{tx: 8'h81, lp: 1'b1, tie: 1'b0, inj: -1, inj_tx: 8'h00, exp_rx: 8'h81}, "after_rst");

        // Start held high: back-to-back transfers with one idle cycle between.
        loop_en = 1'b1; tx_data = 8'h5A; start = 1'b1;
        ndone = 0; rx_ok = 1'b1;
        for (int k = 0; k < 4; k++) dcyc[k] = 0;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 110; cyc++) begin
            if (done) begin
                if (ndone < 4) dcyc[ndone] = cyc;
                ndone++;
                if (rx_data !== 8'h5A) rx_ok = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("held done_count", ndone, 3);
        chk("held first_done", dcyc[0], DONE_CYC);
        chk("held spacing1", dcyc[1] - dcyc[0], 2 + 16 * D);
        chk("held spacing2", dcyc[2] - dcyc[1], 2 + 16 * D);
        chk("held rx_each", rx_ok, 1'b1);
        chk("held idle_after", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
